// File: rtl/btb_sa_if.sv
// btb_sa_if: bundles the lookup, update, flush and prediction signals of the branch target buffer.
// Latency: none; this is wiring only.
// Backpressure: none; the master drives requests and the slave returns predictions plus busy.
// Ports: master = requester (drives flush/lookup/update, samples prediction/busy);
//        slave  = btb_sa (the reverse directions).
interface btb_sa_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            lookup_valid_i;
  logic [XLEN-1:0] pc_i;
  logic            update_valid_i;
  logic            del_entry_i;
  logic [XLEN-1:0] res_pc_i;
  logic [XLEN-1:0] res_target_i;
  logic            pred_valid_o;
  logic            hit_o;
  logic [XLEN-1:0] pred_target_o;
  logic            busy_o;

  modport master (
    output flush_i, lookup_valid_i, pc_i, update_valid_i, del_entry_i, res_pc_i, res_target_i,
    input  pred_valid_o, hit_o, pred_target_o, busy_o
  );

  modport slave (
    input  flush_i, lookup_valid_i, pc_i, update_valid_i, del_entry_i, res_pc_i, res_target_i,
    output pred_valid_o, hit_o, pred_target_o, busy_o
  );
endinterface

// File: rtl/btb_sa.sv
// btb_sa: set-associative branch target buffer, round-robin victim per set, set-walking flush.
// Latency: lookup result registered one cycle after lookup_valid_i; updates take effect next cycle.
// Backpressure: none; lookups always answered, updates dropped while busy_o (flush walk) is high.
// Ports: clk_i, rst_n_i (async active-low), bus (btb_sa_if.slave) with lookup, update, flush,
//        prediction (pred_valid_o/hit_o/pred_target_o) and busy_o.
module btb_sa #(
  parameter int XLEN   = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int OFFSET = 2
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  btb_sa_if.slave bus
);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = XLEN - IDX - OFFSET;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t         state_q, state_d;
  logic [IDX-1:0] cnt_q, cnt_d;
  logic           clr_set;
  logic           busy;

  // Storage: valid bits and pointers are reset, tag/target arrays are not.
  logic            vld_q [SETS][WAYS];
  logic [TAG-1:0]  tag_q [SETS][WAYS];
  logic [XLEN-1:0] tgt_q [SETS][WAYS];
  logic [WW-1:0]   ptr_q [SETS];

  logic            pred_valid_q;
  logic            hit_q;
  logic [XLEN-1:0] pred_target_q;

  // ---------------- flush walk FSM ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        clr_set = 1'b1;
        // A new flush request restarts the walk from set 0.
        if (bus.flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDX'(SETS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == FLUSH);

  // ---------------- update-side way selection ----------------
  logic [IDX-1:0] u_idx;
  logic [TAG-1:0] u_tag;
  logic           u_hit, u_has_inv;
  logic [WW-1:0]  u_way, u_inv, wr_way, ptr_inc;
  logic           evict;
  logic           upd_en;

  assign u_idx = bus.res_pc_i[IDX+OFFSET-1:OFFSET];
  assign u_tag = bus.res_pc_i[XLEN-1:IDX+OFFSET];

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    u_has_inv = 1'b0;
    u_inv     = '0;
    // Scan downwards so the lowest-numbered invalid way is the one left selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld_q[u_idx][w]) begin
        u_has_inv = 1'b1;
        u_inv     = WW'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = WW'(w);
      end
    end
  end

  assign evict   = !u_hit && !u_has_inv;
  assign wr_way  = u_hit ? u_way : (u_has_inv ? u_inv : ptr_q[u_idx]);
  assign ptr_inc = (WAYS == 1) ? '0 : ptr_q[u_idx] + WW'(1);
  // A flush in the same cycle takes priority and drops the update.
  assign upd_en  = (state_q == IDLE) && !bus.flush_i && bus.update_valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          vld_q[s][w] <= 1'b0;
        end
        ptr_q[s] <= '0;
      end
    end else if (clr_set) begin
      for (int w = 0; w < WAYS; w++) begin
        vld_q[cnt_q][w] <= 1'b0;
      end
      ptr_q[cnt_q] <= '0;
    end else if (upd_en) begin
      if (bus.del_entry_i) begin
        if (u_hit) begin
          vld_q[u_idx][u_way] <= 1'b0;
        end
      end else begin
        vld_q[u_idx][wr_way] <= 1'b1;
        // Pointer only advances when a valid entry is displaced.
        if (evict) begin
          ptr_q[u_idx] <= ptr_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd_en && !bus.del_entry_i) begin
      tag_q[u_idx][wr_way] <= u_tag;
      tgt_q[u_idx][wr_way] <= bus.res_target_i;
    end
  end

  // ---------------- lookup path ----------------
  logic [IDX-1:0]  l_idx;
  logic [TAG-1:0]  l_tag;
  logic            l_hit;
  logic [XLEN-1:0] l_tgt;

  assign l_idx = bus.pc_i[IDX+OFFSET-1:OFFSET];
  assign l_tag = bus.pc_i[XLEN-1:IDX+OFFSET];

  // At most one way can match, so OR-ing the matching targets selects it.
  always_comb begin
    l_hit = 1'b0;
    l_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
        l_hit = 1'b1;
        l_tgt = l_tgt | tgt_q[l_idx][w];
      end
    end
  end

  // Reads the pre-update arrays, so a same-cycle update to the set is not visible yet.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pred_valid_q  <= 1'b0;
      hit_q         <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= bus.lookup_valid_i;
      hit_q         <= bus.lookup_valid_i && !busy && l_hit;
      pred_target_q <= (bus.lookup_valid_i && !busy && l_hit) ? l_tgt : '0;
    end
  end

  assign bus.pred_valid_o  = pred_valid_q;
  assign bus.hit_o         = hit_q;
  assign bus.pred_target_o = pred_target_q;
  assign bus.busy_o        = busy;

  // PC offset bits never take part in index or tag.
  generate
    if (OFFSET > 0) begin : g_offset
      logic unused_offset_bits;
      assign unused_offset_bits = ^{bus.pc_i[OFFSET-1:0], bus.res_pc_i[OFFSET-1:0]};
    end
  endgenerate
endmodule

// File: tb/tb_btb_sa.sv
// tb_btb_sa: randomized and directed stimulus against a queue-based scoreboard for btb_sa.
// Latency: expects each lookup answered at the negedge after the following rising edge.
// Backpressure: none modelled; busy_o is predicted and compared every cycle.
module tb_btb_sa;
  localparam int XLEN   = 32;
  localparam int SETS   = 16;
  localparam int WAYS   = 2;
  localparam int OFFSET = 2;
  localparam int IDX    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btb_sa_if #(.XLEN(XLEN)) bus();

  btb_sa #(.XLEN(XLEN), .SETS(SETS), .WAYS(WAYS), .OFFSET(OFFSET)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic            hit;
    logic [XLEN-1:0] tgt;
    int              due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: plain per-set arrays following the replacement rules directly.
  bit              m_vld [SETS][WAYS];
  int              m_tag [SETS][WAYS];
  logic [XLEN-1:0] m_tgt [SETS][WAYS];
  int              m_ptr [SETS];
  int              m_busy_left = 0;

  function automatic int m_set(logic [XLEN-1:0] pc);
    return int'((pc >> OFFSET) % SETS);
  endfunction

  function automatic int m_tagof(logic [XLEN-1:0] pc);
    return int'(pc >> (IDX + OFFSET));
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
      m_ptr[s] = 0;
    end
  endfunction

  function automatic void model_lookup(logic [XLEN-1:0] pc, output bit h, output logic [XLEN-1:0] t);
    int s;
    s = m_set(pc);
    h = 1'b0;
    t = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_vld[s][w] && m_tag[s][w] == m_tagof(pc)) begin
        h = 1'b1;
        t = m_tgt[s][w];
      end
    end
  endfunction

  function automatic void model_update(logic [XLEN-1:0] pc, bit d, logic [XLEN-1:0] t);
    int s, g, hw, iw, v;
    s = m_set(pc);
    g = m_tagof(pc);
    hw = -1;
    iw = -1;
    for (int w = 0; w < WAYS; w++) if (m_vld[s][w] && m_tag[s][w] == g) hw = w;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_vld[s][w]) iw = w;
    if (d) begin
      if (hw >= 0) m_vld[s][hw] = 1'b0;
    end else if (hw >= 0) begin
      m_tgt[s][hw] = t;
    end else if (iw >= 0) begin
      m_vld[s][iw] = 1'b1;
      m_tag[s][iw] = g;
      m_tgt[s][iw] = t;
    end else begin
      v = m_ptr[s];
      m_tag[s][v] = g;
      m_tgt[s][v] = t;
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares registered outputs and busy_o mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", {31'd0, bus.busy_o}, (m_busy_left > 0) ? 32'd1 : 32'd0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          check("pred_valid", {31'd0, bus.pred_valid_o}, 32'd1);
          check("hit", {31'd0, bus.hit_o}, {31'd0, e.hit});
          check("target", bus.pred_target_o, e.tgt);
        end else begin
          check("pred_valid_idle", {31'd0, bus.pred_valid_o}, 32'd0);
          check("hit_idle", {31'd0, bus.hit_o}, 32'd0);
          check("target_idle", bus.pred_target_o, 32'd0);
        end
      end
    end
  end

  // One clock of stimulus. dir=1 pushes the given constant expectation instead of the model's.
  task automatic cycle(input bit lk, input logic [XLEN-1:0] pc, input bit up, input bit dl,
                       input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] rtgt, input bit fl,
                       input bit dir, input bit eh, input logic [XLEN-1:0] et);
    exp_t e;
    bit mh;
    logic [XLEN-1:0] mt;
    int nb;
    bus.lookup_valid_i = lk;
    bus.pc_i           = pc;
    bus.update_valid_i = up;
    bus.del_entry_i    = dl;
    bus.res_pc_i       = rpc;
    bus.res_target_i   = rtgt;
    bus.flush_i        = fl;
    if (lk) begin
      model_lookup(pc, mh, mt);
      if (m_busy_left > 0) begin
        mh = 1'b0;
        mt = '0;
      end
      e.hit = dir ? eh : mh;
      e.tgt = dir ? et : mt;
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
    // A flush invalidates everything at once in the model; lookups miss while busy anyway.
    nb = m_busy_left;
    if (m_busy_left > 0) nb = fl ? SETS : m_busy_left - 1;
    else if (fl) begin
      model_clear();
      nb = SETS;
    end else if (up) model_update(rpc, dl, rtgt);
    @(posedge clk);
    #1;
    m_busy_left = nb;
  endtask

  task automatic look(input logic [XLEN-1:0] pc, input bit eh, input logic [XLEN-1:0] et);
    cycle(1'b1, pc, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, eh, et);
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] t);
    cycle(1'b0, '0, 1'b1, 1'b0, pc, t, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic del(input logic [XLEN-1:0] pc);
    cycle(1'b0, '0, 1'b1, 1'b1, pc, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_inputs();
    bus.lookup_valid_i = 1'b0;
    bus.pc_i           = '0;
    bus.update_valid_i = 1'b0;
    bus.del_entry_i    = 1'b0;
    bus.res_pc_i       = '0;
    bus.res_target_i   = '0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
    check({tag, "_pred_valid"}, {31'd0, bus.pred_valid_o}, 32'd0);
    check({tag, "_hit"}, {31'd0, bus.hit_o}, 32'd0);
    check({tag, "_target"}, bus.pred_target_o, 32'd0);
  endtask

  initial begin
    logic [XLEN-1:0] pc, rpc, tgt;
    bit lk, up, dl, fl;
    clear_inputs();
    model_clear();
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Cold lookup, install, hit, same-set different tag.
    look(32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h200);
    look(32'h100, 1'b1, 32'h200);
    look(32'h140, 1'b0, 32'h0);

    // Overwrite, fill, evict; victim pointer of set 0 ends at 1.
    upd(32'h100, 32'hA);
    upd(32'h140, 32'hB);
    upd(32'h180, 32'hC);
    look(32'h100, 1'b0, 32'h0);
    look(32'h140, 1'b1, 32'hB);
    look(32'h180, 1'b1, 32'hC);

    // Delete of a non-resident PC changes nothing; next eviction uses way 1.
    del(32'h1C0);
    look(32'h140, 1'b1, 32'hB);
    upd(32'h1C0, 32'hD);
    look(32'h140, 1'b0, 32'h0);
    look(32'h180, 1'b1, 32'hC);
    look(32'h1C0, 1'b1, 32'hD);

    // Delete resident entry, refill lowest invalid way without moving the pointer.
    del(32'h180);
    look(32'h180, 1'b0, 32'h0);
    upd(32'h100, 32'hE);
    upd(32'h140, 32'hF);
    look(32'h100, 1'b0, 32'h0);
    look(32'h1C0, 1'b1, 32'hD);
    look(32'h140, 1'b1, 32'hF);

    // Same-cycle lookup and update to the same entry returns the old target.
    cycle(1'b1, 32'h1C0, 1'b1, 1'b0, 32'h1C0, 32'h55, 1'b0, 1'b1, 1'b1, 32'hD);
    look(32'h1C0, 1'b1, 32'h55);

    // Install four entries, flush with a same-cycle lookup, update at busy cycle 3 is ignored.
    upd(32'h104, 32'h11);
    upd(32'h108, 32'h22);
    upd(32'h10C, 32'h33);
    upd(32'h110, 32'h44);
    look(32'h104, 1'b1, 32'h11);
    cycle(1'b1, 32'h108, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 32'h22);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 32'h104, (k == 3), 1'b0, 32'h104, 32'h99, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    look(32'h104, 1'b0, 32'h0);
    look(32'h108, 1'b0, 32'h0);
    look(32'h10C, 1'b0, 32'h0);
    look(32'h110, 1'b0, 32'h0);
    look(32'h1C0, 1'b0, 32'h0);

    // Flush and update in the same idle cycle: update dropped. Flush restarted mid-walk.
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h114, 32'h77, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 16; k++) idle();
    look(32'h114, 1'b0, 32'h0);

    // Reset in the middle of a flush walk.
    upd(32'h104, 32'h11);
    look(32'h104, 1'b1, 32'h11);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) idle();
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_outputs_zero("midflush_reset");
    exp_q.delete();
    model_clear();
    m_busy_left = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    look(32'h104, 1'b0, 32'h0);
    upd(32'h104, 32'h21);
    look(32'h104, 1'b1, 32'h21);

    // Randomized traffic over a small PC pool to force hits, conflicts and evictions.
    for (int n = 0; n < 3000; n++) begin
      pc  = 32'(($urandom_range(4, 9) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      rpc = 32'(($urandom_range(4, 9) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      tgt = $urandom;
      lk  = ($urandom_range(0, 9) < 7);
      up  = ($urandom_range(0, 1) == 1);
      dl  = ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 149) == 0);
      cycle(lk, pc, up, dl, rpc, tgt, fl, 1'b0, 1'b0, '0);
    end

    idle();
    idle();
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
